// File: rtl/tdpram_port_arbiter.sv
// =============================================================================
// tdpram_port_arbiter
// -----------------------------------------------------------------------------
// Shares one port of a true-dual-port block RAM between NUM_REQ requesters.
// Requesters issue single-beat reads or byte-masked writes with a valid/ready
// handshake. A round-robin arbiter picks at most one requester per cycle, and
// that requester's fields are driven straight onto the RAM port. Every accepted
// read pushes its requester id into a READ_LATENCY-deep tag pipeline. When the
// tag reaches the last stage, the RAM's dout is steered back to the issuer.
//
// Optional feature (compile-time macro TDPRAM_ARB_LOCK_EN):
//   When the macro is defined, a requester that is accepted with req_lock=1
//   keeps exclusive ownership of the port. Ownership ends at its first accepted
//   beat with req_lock=0. When the macro is undefined, req_lock is ignored.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   ADDR_WIDTH   RAM word address width
//   DATA_WIDTH   RAM data width, multiple of 8
//   READ_LATENCY RAM cycles from en to valid dout (1..8)
//
// Ports:
//   clk        single clock for all logic
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept, one-hot or zero
//   req_addr   flat packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_din    flat packed write data
//   req_we     flat packed byte write enables, all-zero means read
//   req_lock   hold the grant after this beat (lock build only)
//   rsp_valid  read data valid for requester i, one-hot or zero
//   rsp_dout   read data, broadcast to all requesters
//   mem_addr   RAM port address
//   mem_din    RAM port write data
//   mem_en     RAM port enable
//   mem_we     RAM port byte write enables
//   mem_dout   RAM port read data
// =============================================================================
module tdpram_port_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_din,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_we,
    input  logic [NUM_REQ-1:0]                req_lock,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_dout,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_din,
    output logic                              mem_en,
    output logic [(DATA_WIDTH/8)-1:0]         mem_we,
    input  logic [DATA_WIDTH-1:0]             mem_dout
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]      eligible;
    logic                    grant_found;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic                    accept;
    logic                    is_read;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_din;
    logic [STROBE_WIDTH-1:0] sel_we;

    logic                    tag_valid [READ_LATENCY];
    logic [ID_WIDTH-1:0]     tag_id    [READ_LATENCY];

`ifdef TDPRAM_ARB_LOCK_EN
    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    lock_state_t         lock_state;
    lock_state_t         lock_state_next;
    logic [ID_WIDTH-1:0] lock_owner;
    logic [ID_WIDTH-1:0] lock_owner_next;
    logic                sel_lock;
    logic [NUM_REQ-1:0]  owner_mask;

    assign sel_lock   = req_lock[grant_idx];
    assign owner_mask = NUM_REQ'(1) << lock_owner;

    // While locked, only the owner may compete. It is masked here instead of
    // in the FSM block so that the arbiter does not depend combinationally on
    // the block that also consumes the accept.
    assign eligible = (lock_state == LOCKED) ? (req_valid & owner_mask) : req_valid;

    // Lock state register. Reset always returns the port to shared use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state <= UNLOCKED;
            lock_owner <= '0;
        end else begin
            lock_state <= lock_state_next;
            lock_owner <= lock_owner_next;
        end
    end

    // Lock next-state. A locked beat captures the owner. The owner's first
    // unlocked beat releases the port. The round-robin pointer advances past
    // the owner on that beat in the usual way.
    always_comb begin
        lock_state_next = lock_state;
        lock_owner_next = lock_owner;
        case (lock_state)
            UNLOCKED: begin
                if (accept && sel_lock) begin
                    lock_state_next = LOCKED;
                    lock_owner_next = grant_idx;
                end
            end
            LOCKED: begin
                if (accept && !sel_lock) begin
                    lock_state_next = UNLOCKED;
                end
            end
            default: begin
                lock_state_next = UNLOCKED;
            end
        endcase
    end
`else
    logic unused_lock;

    assign eligible    = req_valid;
    assign unused_lock = ^req_lock;
`endif

    // Round-robin pick. The first pass scans indices at or above the pointer
    // and the second pass scans those below it. Together they give the first
    // eligible index at or after rr_ptr with wrap-around, and they need no
    // modulo arithmetic.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && eligible[i] && (ID_WIDTH'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && eligible[i] && (ID_WIDTH'(i) < rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(i);
            end
        end
    end

    // The grant is combinational, so it is gated with reset. This keeps
    // nothing on the RAM port and nothing handed out while reset is held.
    assign accept  = grant_found && !rst;
    assign is_read = accept && (sel_we == '0);

    // Steer the winning requester's fields. A compare-per-index mux is used
    // instead of a computed part-select. This keeps the index arithmetic
    // within the id width.
    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_din  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we   = req_we[i*STROBE_WIDTH +: STROBE_WIDTH];
            end
        end
    end

    // RAM port and handshake outputs. The address, data and strobes are zero
    // whenever nothing is accepted, so an idle port never shows stale fields.
    always_comb begin
        req_ready = '0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        mem_we    = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
            mem_en               = 1'b1;
            mem_addr             = sel_addr;
            mem_din              = sel_din;
            mem_we               = sel_we;
        end
    end

    // Round-robin pointer. It moves just past the requester that was served,
    // so that requester becomes lowest priority next cycle. It holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // Tag pipeline, one stage per RAM read cycle. It shifts every cycle, so a
    // tag pops out exactly when the RAM presents the matching dout. Clearing
    // it on reset discards reads that were in flight, and their late data is
    // never reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_valid[s] <= 1'b0;
                tag_id[s]    <= '0;
            end
        end else begin
            tag_valid[0] <= is_read;
            tag_id[0]    <= grant_idx;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    // Read response. The data is a straight pass-through of the RAM. Only the
    // valid strobe is routed, to the requester named by the last tag stage.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_valid[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == ID_WIDTH'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_dout = mem_dout;

endmodule

// File: tb/tb_tdpram_port_arbiter.sv
// =============================================================================
// tb_tdpram_port_arbiter
// -----------------------------------------------------------------------------
// Self-checking bench for tdpram_port_arbiter. A behavioural RAM sits on the
// mem_* port. A reference model keeps its own round-robin pointer, lock state
// and shadow memory. At every accept it predicts the grant and the port
// fields, and it queues the expected read response. A separate monitor pops
// that queue whenever rsp_valid is seen, or when a response comes due.
// =============================================================================
module tb_tdpram_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 12;
    localparam int DW      = 32;
    localparam int RL      = 2;
    localparam int SW      = DW / 8;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_din;
    logic [NUM_REQ*SW-1:0] req_we;
    logic [NUM_REQ-1:0]    req_lock;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_dout;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_din;
    logic                  mem_en;
    logic [SW-1:0]         mem_we;
    logic [DW-1:0]         mem_dout;

    tdpram_port_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    // Cycle counter, advanced at each active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Power-on RAM contents, with the two words the directed tests rely on
    function automatic logic [DW-1:0] initWord(input int adr);
        if (adr == 32'h010) return 32'hDEADBEEF;
        if (adr == 32'h020) return 32'h12345678;
        return 32'h9E3779B9 ^ (32'(adr) * 32'h00010001);
    endfunction

    // Behavioural read-first RAM with an RL-cycle output pipeline
    logic [DW-1:0] ram        [1<<AW];
    bit            ram_written[1<<AW];
    logic [DW-1:0] rd_pipe    [RL];
    logic [DW-1:0] ram_base;
    logic [DW-1:0] ram_merged;

    always @(posedge clk) begin
        if (mem_en) begin
            ram_base = ram_written[mem_addr] ? ram[mem_addr] : initWord(int'(mem_addr));
            rd_pipe[0] <= ram_base;
            if (mem_we != '0) begin
                ram_merged = ram_base;
                for (int b = 0; b < SW; b++)
                    if (mem_we[b]) ram_merged[b*8 +: 8] = mem_din[b*8 +: 8];
                ram[mem_addr]         <= ram_merged;
                ram_written[mem_addr] <= 1'b1;
            end
        end
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_dout = rd_pipe[RL-1];

    // Reference model state
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] shadow[1<<AW];
    int            model_ptr = 0;
    bit            model_locked = 1'b0;
    int            model_owner = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Grant rule: the lock owner only, or the first valid index at or after
    // the pointer, wrapping around
    function automatic int predictGrant(input logic [NUM_REQ-1:0] v);
`ifdef TDPRAM_ARB_LOCK_EN
        if (model_locked) return v[model_owner] ? model_owner : -1;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (model_ptr + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic modelCycle(input logic r, input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*AW-1:0] a,
                              input logic [NUM_REQ*DW-1:0] d, input logic [NUM_REQ*SW-1:0] w,
                              input logic [NUM_REQ-1:0] l);
        int                 g;
        logic [NUM_REQ-1:0] er;
        logic [AW-1:0]      ea;
        logic [DW-1:0]      ed;
        logic [SW-1:0]      ew;
        logic [DW-1:0]      merged;
        if (r) begin
            checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
            checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
            checkOutput("reset_mem_en",    64'(mem_en),    64'd0);
            checkOutput("reset_mem_we",    64'(mem_we),    64'd0);
            checkOutput("reset_mem_addr",  64'(mem_addr),  64'd0);
            checkOutput("reset_mem_din",   64'(mem_din),   64'd0);
            model_ptr    = 0;
            model_locked = 1'b0;
            model_owner  = 0;
            return;
        end
        g  = predictGrant(v);
        er = '0;
        ea = '0;
        ed = '0;
        ew = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            ea    = a[g*AW +: AW];
            ed    = d[g*DW +: DW];
            ew    = w[g*SW +: SW];
        end
        checkOutput("req_ready", 64'(req_ready), 64'(er));
        checkOutput("mem_en",    64'(mem_en),    64'(g >= 0));
        checkOutput("mem_addr",  64'(mem_addr),  64'(ea));
        checkOutput("mem_din",   64'(mem_din),   64'(ed));
        checkOutput("mem_we",    64'(mem_we),    64'(ew));
        if (g >= 0) begin
            if (ew == '0) begin
                sbq.push_back('{cyc + RL, g, shadow[ea]});
            end else begin
                merged = shadow[ea];
                for (int b = 0; b < SW; b++)
                    if (ew[b]) merged[b*8 +: 8] = ed[b*8 +: 8];
                shadow[ea] = merged;
            end
            model_ptr = (g + 1) % NUM_REQ;
`ifdef TDPRAM_ARB_LOCK_EN
            if (!model_locked && l[g]) begin
                model_locked = 1'b1;
                model_owner  = g;
            end else if (model_locked && !l[g]) begin
                model_locked = 1'b0;
            end
`else
            if (l != l) $display("[TB] unreachable");
`endif
        end
    endtask

    // Drive one cycle of inputs just after the edge, then check mid-cycle
    task automatic applyStimulus(input logic r, input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*AW-1:0] a,
                                 input logic [NUM_REQ*DW-1:0] d, input logic [NUM_REQ*SW-1:0] w,
                                 input logic [NUM_REQ-1:0] l);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        req_addr  = a;
        req_din   = d;
        req_we    = w;
        req_lock  = l;
        @(negedge clk);
        modelCycle(r, v, a, d, w, l);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0, '0);
    endtask

    // Response monitor: pops the scoreboard independently of the stimulus
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else if (rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                checkOutput("rsp_cycle", 64'(cyc),       64'(mon_e.due));
                checkOutput("rsp_valid", 64'(rsp_valid), 64'(1 << mon_e.id));
                checkOutput("rsp_dout",  64'(rsp_dout),  64'(mon_e.data));
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e = sbq.pop_front();
            checkOutput("rsp_missing", 64'(rsp_valid), 64'(1 << mon_e.id));
        end
    end

    logic [NUM_REQ-1:0]    sv;
    logic [NUM_REQ*AW-1:0] sa;
    logic [NUM_REQ*DW-1:0] sd;
    logic [NUM_REQ*SW-1:0] sw;
    logic [NUM_REQ-1:0]    sl;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_din   = '0;
        req_we    = '0;
        req_lock  = '0;
        for (int i = 0; i < (1 << AW); i++) shadow[i] = initWord(i);

        $display("[TB] reset with both requesters valid");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b11, {12'h002, 12'h001}, '0, '0, '0);
        idle(2);

        $display("[TB] single read of 0x010");
        applyStimulus(1'b0, 2'b01, {12'h000, 12'h010}, '0, '0, '0);
        idle(3);

        $display("[TB] two requesters streaming reads");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 2'b11, {12'h002, 12'h001}, '0, '0, '0);
        idle(3);

        $display("[TB] partial write then read back");
        applyStimulus(1'b0, 2'b10, {12'h020, 12'h000}, {32'hA5A5A5A5, 32'h0}, {4'b0011, 4'b0000}, '0);
        applyStimulus(1'b0, 2'b01, {12'h000, 12'h020}, '0, '0, '0);
        idle(3);

        $display("[TB] late joiner");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b10, {12'h005, 12'h004}, '0, '0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b11, {12'h005, 12'h004}, '0, '0, '0);
        idle(3);

        $display("[TB] lock sequence");
        applyStimulus(1'b0, 2'b10, {12'h007, 12'h006}, '0, '0, '0);
        applyStimulus(1'b0, 2'b11, {12'h007, 12'h006}, '0, '0, 2'b01);
        applyStimulus(1'b0, 2'b11, {12'h007, 12'h006}, '0, '0, 2'b01);
        applyStimulus(1'b0, 2'b11, {12'h007, 12'h006}, '0, '0, 2'b00);
        applyStimulus(1'b0, 2'b11, {12'h007, 12'h006}, '0, '0, 2'b00);
        idle(3);

        $display("[TB] reset while a read is in flight");
        applyStimulus(1'b0, 2'b01, {12'h000, 12'h010}, '0, '0, '0);
        applyStimulus(1'b1, 2'b00, '0, '0, '0, '0);
        applyStimulus(1'b1, 2'b00, '0, '0, '0, '0);
        applyStimulus(1'b0, 2'b11, {12'h009, 12'h008}, '0, '0, '0);
        idle(4);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                sv[i]            = ($urandom_range(0, 3) != 0);
                sa[i*AW +: AW]   = AW'($urandom_range(0, 63));
                sd[i*DW +: DW]   = $urandom();
                sw[i*SW +: SW]   = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom_range(1, (1 << SW) - 1));
                sl[i]            = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(($urandom_range(0, 199) == 0), sv, sa, sd, sw, sl);
        end
        idle(RL + 3);

        checkOutput("sb_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tdpram_port_arbiter.md
Name: tdpram_port_arbiter

Overview:
Shares one port of a true-dual-port block RAM among NUM_REQ requesters using round-robin arbitration. Each requester issues single-beat read/write requests with a valid/ready handshake. The arbiter drives the RAM port (addr/din/en/we) and tracks in-flight reads through a READ_LATENCY-deep tag pipeline, so each read's data returns to the requester that issued it. It sits between the processing cores and a RAM port master, which is the only RAM access path for those requesters.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 12, RAM word address width
DATA_WIDTH, 32, RAM data width (multiple of 8); STROBE_WIDTH = DATA_WIDTH/8
READ_LATENCY, 2, RAM clock cycles from en to valid dout (1..8)

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
req_addr  in  NUM_REQ*ADDR_WIDTH  flat packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_din  in  NUM_REQ*DATA_WIDTH  flat packed write data
req_we  in  NUM_REQ*STROBE_WIDTH  flat packed byte write enables; all-zero means read
req_lock  in  NUM_REQ  hold the grant after this beat (used only with TDPRAM_ARB_LOCK_EN)
rsp_valid  out  NUM_REQ  read data valid for requester i, one-hot or zero
rsp_dout  out  DATA_WIDTH  read data, broadcast to all requesters
mem_addr  out  ADDR_WIDTH  RAM port address
mem_din  out  DATA_WIDTH  RAM port write data
mem_en  out  1  RAM port enable
mem_we  out  STROBE_WIDTH  RAM port byte write enables
mem_dout  in  DATA_WIDTH  RAM port read data

Behaviour:
- Reset (async, active-high): rr_ptr=0; tag pipeline valid bits=0; lock state cleared. Outputs during reset: req_ready=0, rsp_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0. Reads in flight at reset are dropped, and their late mem_dout is never reported.
- Arbitration is combinational within the cycle. Among asserted req_valid, grant goes to the first index at or after rr_ptr, wrapping modulo NUM_REQ. req_ready[g]=1 only for the granted requester. No valid request means no grant, req_ready=0, mem_en=0.
- Accept occurs when req_valid[g]&req_ready[g]. In the same cycle: mem_en=1, mem_addr/mem_din/mem_we = requester g's fields. When not accepting: mem_we=0, and mem_addr/mem_din hold 0.
- Pointer update on accept: rr_ptr <= (g+1) mod NUM_REQ. No update when idle.
- Throughput: one access per cycle and no bubbles. A single requester asserting valid continuously is accepted every cycle.
- Tag pipeline: READ_LATENCY stages of {valid, id[$clog2(NUM_REQ)]}. Stage 0 loads {accept & (req_we==0), g}, and the pipeline shifts every cycle.
- Read response: rsp_valid[id]=last-stage valid; rsp_dout=mem_dout, combinational pass-through. Read latency from accept edge to rsp_valid is exactly READ_LATENCY cycles. Writes produce no response.
- No response backpressure: requesters must sink rsp_valid in the cycle it is asserted.
- A requester dropping req_valid without being granted is legal; nothing is recorded.
- Read-after-write from different requesters to the same address in consecutive cycles is ordered by grant order. Data follows the RAM's write mode, and the arbiter adds no forwarding.

Optional Feature:
Macro: TDPRAM_ARB_LOCK_EN.
- Defined: when an accept occurs with req_lock[g]=1, the arbiter enters LOCKED(g).
  - In LOCKED, only requester g can be granted; other requesters see ready=0 even if g is idle.
  - LOCKED exits on the first accept from g with req_lock[g]=0. rr_ptr then becomes (g+1) mod NUM_REQ.
  - States: UNLOCKED → LOCKED(g) → UNLOCKED.
  - Reset forces UNLOCKED.
- Undefined: req_lock is ignored and no lock state exists.

Test Plan:
1. Reset mid-read: read accepted, rst asserted 1 cycle later → rsp_valid never asserts; after release, outputs are 0 and rr_ptr=0.
2. Single requester 0 reads addr 0x010 with READ_LATENCY=2 after the RAM is preloaded with 0xDEADBEEF → mem_en=1, mem_addr=0x010 in the accept cycle; rsp_valid=2'b01, rsp_dout=0xDEADBEEF exactly 2 cycles later.
3. Both requesters hold valid for 6 cycles (reads, addr 0x1/0x2) → grants alternate 0,1,0,1,0,1; rsp_valid alternates 01,10 starting at cycle 2; no idle cycles.
4. Requester 1 writes 0xA5A5A5A5 to 0x20 with we=4'b0011 → mem_we=4'b0011 for one cycle and no rsp_valid. A read of 0x20 then returns the original upper bytes with low bytes 0xA5A5.
5. Requester 1 only valid for 3 cycles, then requester 0 joins → three back-to-back grants to 1, then fair alternation starting with 0.
6. With TDPRAM_ARB_LOCK_EN: requester 0 issues 3 beats with lock=1,1,0 while requester 1 is continuously valid → requester 1 gets ready=0 for those 3 beats, then is granted next cycle. Without the macro → grants alternate.
